// File: rtl/code_maker.sv
// Codemaker-side mastermind controller: collects a 4-symbol secret, hands off to the codebreaker, picks the next maker.
// Optional macro CODE_NO_REPEAT_EN refuses symbols already present in the current code.
module code_maker #(
  parameter int unsigned FIRST_MAKER = 0,
  parameter int unsigned MAX_ROUNDS  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  SW,
  input  logic        enterA,
  input  logic        enterB,
  input  logic        codeMaker,
  input  logic        pickPlayerA,
  input  logic        pickPlayerB,
  input  logic [1:0]  round_counter,
  output logic [11:0] codemaker_code,
  output logic        codeBreaker,
  output logic        player_A,
  output logic        player_B,
  output logic        maker_is_B,
  output logic [2:0]  symbols_entered,
  output logic        reject,
  output logic        game_over
);

  localparam int unsigned SYM_W   = 3;
  localparam int unsigned NUM_SYM = 4;
  localparam int unsigned CODE_W  = SYM_W * NUM_SYM;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_HANDOFF,
    S_WAIT_BREAKER,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cb_q, cb_d;
  logic                pa_q, pa_d;
  logic                pb_q, pb_d;
  logic                maker_q, maker_d;
  logic                rej_q, rej_d;
  logic                go_q, go_d;
  logic                active_enter;
  logic                refuse;

  assign active_enter = maker_q ? enterB : enterA;

`ifdef CODE_NO_REPEAT_EN
  // Symbol already present among the ones entered so far; newest symbol sits in the low bits.
  always_comb begin
    refuse = 1'b0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if ((CNT_W'(i) < cnt_q) && (code_q[i*SYM_W +: SYM_W] == SW)) begin
        refuse = 1'b1;
      end
    end
  end
`else
  assign refuse = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    cb_d    = 1'b0;
    pa_d    = 1'b0;
    pb_d    = 1'b0;
    maker_d = maker_q;
    rej_d   = 1'b0;
    go_d    = go_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ENTER;
          code_d  = '0;
          cnt_d   = '0;
        end
      end
      S_ENTER: begin
        if (active_enter) begin
          if (refuse) begin
            rej_d = 1'b1;
          end else begin
            code_d = {code_q[CODE_W-SYM_W-1:0], SW};
            cnt_d  = cnt_q + CNT_W'(1);
            // Last symbol: raise the handoff pulse together with the state change.
            if (cnt_q == CNT_W'(NUM_SYM - 1)) begin
              state_d = S_HANDOFF;
              cb_d    = 1'b1;
              pa_d    = maker_q;
              pb_d    = ~maker_q;
            end
          end
        end
      end
      S_HANDOFF: begin
        state_d = S_WAIT_BREAKER;
      end
      S_WAIT_BREAKER: begin
        if (codeMaker) begin
          if (pickPlayerA) begin
            maker_d = 1'b0;
          end else if (pickPlayerB) begin
            maker_d = 1'b1;
          end else begin
            maker_d = ~maker_q;
          end
          if (32'(round_counter) >= MAX_ROUNDS) begin
            state_d = S_DONE;
            go_d    = 1'b1;
          end else begin
            state_d = S_ENTER;
            code_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      S_DONE: begin
        go_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      cb_q    <= 1'b0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      maker_q <= 1'(FIRST_MAKER);
      rej_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      cb_q    <= cb_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      maker_q <= maker_d;
      rej_q   <= rej_d;
      go_q    <= go_d;
    end
  end

  assign codemaker_code  = code_q;
  assign codeBreaker     = cb_q;
  assign player_A        = pa_q;
  assign player_B        = pb_q;
  assign maker_is_B      = maker_q;
  assign symbols_entered = cnt_q;
  assign reject          = rej_q;
  assign game_over       = go_q;

endmodule
